// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch per cycle to a 1-cycle
// instruction memory, absorbs decode stalls with a one-entry skid, flushes on redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_v_q, inflight_v_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            skid_v_q, skid_v_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_inst_q, skid_inst_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;

  logic req;
  logic advance;

  // Request is withheld whenever the skid is full or about to fill.
  assign req = rst_n && !redirect_valid && !skid_v_q
               && !(id_stall && id_valid_q && inflight_v_q);
  assign advance = !id_valid_q || !id_stall;

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_v_d  = inflight_v_q;
    inflight_pc_d = inflight_pc_q;
    skid_v_d      = skid_v_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;

    if (redirect_valid) begin
      // Flush everything; the response landing next cycle is dropped via inflight_v=0.
      pc_d         = redirect_pc & ALIGN_MASK;
      inflight_v_d = 1'b0;
      skid_v_d     = 1'b0;
      id_valid_d   = 1'b0;
      id_inst_d    = NOP_INST;
    end else begin
      if (req) begin
        pc_d          = pc_q + PC_STEP;
        inflight_v_d  = 1'b1;
        inflight_pc_d = pc_q;
      end else begin
        inflight_v_d  = 1'b0;
      end

      if (advance) begin
        if (skid_v_q) begin
          id_valid_d = 1'b1;
          id_pc_d    = skid_pc_q;
          id_inst_d  = skid_inst_q;
          skid_v_d   = 1'b0;
        end else if (inflight_v_q) begin
          id_valid_d = 1'b1;
          id_pc_d    = inflight_pc_q;
          id_inst_d  = imem_rdata;
        end else begin
          id_valid_d = 1'b0;
          id_inst_d  = NOP_INST;
        end
      end else if (inflight_v_q) begin
        skid_v_d    = 1'b1;
        skid_pc_d   = inflight_pc_q;
        skid_inst_d = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC_AL;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= RESET_PC_AL;
      skid_v_q      <= 1'b0;
      skid_pc_q     <= RESET_PC_AL;
      skid_inst_q   <= NOP_INST;
      id_valid_q    <= 1'b0;
      id_pc_q       <= RESET_PC;
      id_inst_q     <= NOP_INST;
    end else begin
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      skid_v_q      <= skid_v_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, stall/skid, redirects, async reset,
// and PC wrap on a second instance started near the top of the address space.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        req_a, valid_a;
  logic [31:0] addr_a, rdata_a, pc_a, inst_a;
  logic        req_w, valid_w;
  logic [31:0] addr_w, rdata_w, pc_w, inst_w;

  int n_cmp;
  int n_err;

  if_fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .id_valid(valid_a), .id_pc(pc_a), .id_inst(inst_a)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_stall(1'b0),
    .id_valid(valid_w), .id_pc(pc_w), .id_inst(inst_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle instruction memory whose contents are addr ^ 0xA5A5_0000.
  always @(posedge clk) begin
    rdata_a <= addr_a ^ 32'hA5A5_0000;
    rdata_w <= addr_w ^ 32'hA5A5_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(valid_a), 32'(v));
    chk({tag, "_pc"}, pc_a, pc);
    chk({tag, "_inst"}, inst_a, inst);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    repeat (2) step();
    chk_id("rst", 1'b0, 32'h0, 32'h13);
    chk("rst_req", 32'(req_a), 32'd0);
    chk("rst_wrap_pc", pc_w, 32'hFFFF_FFF8);

    // Cycle 0
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("c0_req", 32'(req_a), 32'd1);
    chk("c0_addr", addr_a, 32'h0);
    step(); // cycle 1
    chk("c1_valid", 32'(valid_a), 32'd0);
    chk("c1_addr", addr_a, 32'h4);
    step(); // cycle 2
    chk_id("c2", 1'b1, 32'h0, 32'hA5A5_0000);
    chk("w2_pc", pc_w, 32'hFFFF_FFF8);
    chk("w2_inst", inst_w, 32'h5A5A_FFF8);
    step(); // cycle 3
    chk_id("c3", 1'b1, 32'h4, 32'hA5A5_0004);
    chk("w3_pc", pc_w, 32'hFFFF_FFFC);
    chk("w3_inst", inst_w, 32'h5A5A_FFFC);
    step(); // cycle 4
    chk_id("c4", 1'b1, 32'h8, 32'hA5A5_0008);
    chk("w4_pc", pc_w, 32'h0);
    chk("w4_inst", inst_w, 32'hA5A5_0000);
    chk("w4_valid", 32'(valid_w), 32'd1);

    // Stall cycles 4,5,6 with 0xC inflight
    id_stall = 1'b1;
    #1;
    chk("s4_req", 32'(req_a), 32'd0);
    step(); // cycle 5
    chk_id("s5", 1'b1, 32'h8, 32'hA5A5_0008);
    chk("s5_req", 32'(req_a), 32'd0);
    step(); // cycle 6
    chk_id("s6", 1'b1, 32'h8, 32'hA5A5_0008);
    chk("s6_req", 32'(req_a), 32'd0);
    step(); // cycle 7: stall released, skid drains at end
    id_stall = 1'b0;
    #1;
    chk_id("e7", 1'b1, 32'h8, 32'hA5A5_0008);
    chk("e7_req", 32'(req_a), 32'd0);
    step(); // cycle 8
    chk_id("e8", 1'b1, 32'hC, 32'hA5A5_000C);
    chk("e8_req", 32'(req_a), 32'd1);
    chk("e8_addr", addr_a, 32'h10);
    step(); // cycle 9: bubble, 0x10 inflight
    chk_id("e9", 1'b0, 32'hC, 32'h13);

    // Redirect to 0x100 while 0x10 inflight
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("r9_req", 32'(req_a), 32'd0);
    step(); // cycle 10
    redirect_valid = 1'b0;
    #1;
    chk("r10_valid", 32'(valid_a), 32'd0);
    chk("r10_inst", inst_a, 32'h13);
    chk("r10_addr", addr_a, 32'h100);
    chk("r10_req", 32'(req_a), 32'd1);
    step(); // cycle 11
    chk("r11_valid", 32'(valid_a), 32'd0);
    chk("r11_inst", inst_a, 32'h13);
    step(); // cycle 12
    chk_id("r12", 1'b1, 32'h100, 32'hA5A5_0100);
    step(); // cycle 13
    chk_id("r13", 1'b1, 32'h104, 32'hA5A5_0104);

    // Stall fills skid with 0x108, then redirect to 0x203 while stalled
    id_stall = 1'b1;
    step(); // cycle 14
    chk_id("k14", 1'b1, 32'h104, 32'hA5A5_0104);
    chk("k14_req", 32'(req_a), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step(); // cycle 15: stall still high but output invalid
    redirect_valid = 1'b0;
    #1;
    chk_id("k15", 1'b0, 32'h104, 32'h13);
    chk("k15_addr", addr_a, 32'h200);
    chk("k15_req", 32'(req_a), 32'd1);
    step(); // cycle 16
    chk("k16_valid", 32'(valid_a), 32'd0);
    step(); // cycle 17
    chk_id("k17", 1'b1, 32'h200, 32'hA5A5_0200);
    id_stall = 1'b0;
    step(); // cycle 18
    chk_id("k18", 1'b1, 32'h204, 32'hA5A5_0204);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_id("ar", 1'b0, 32'h0, 32'h13);
    chk("ar_req", 32'(req_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar0_req", 32'(req_a), 32'd1);
    chk("ar0_addr", addr_a, 32'h0);
    step();
    step();
    chk_id("ar2", 1'b1, 32'h0, 32'hA5A5_0000);
    step();
    chk_id("ar3", 1'b1, 32'h4, 32'hA5A5_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
